spi_xfer_arbiter: RTL and testbench
===================================

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per SPI transfer; legal range 4..32.
REQ-002 Parameter CLK_DIV, default 2: clock cycles per SCK half-period; legal range 1..255.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester transfer request; bit i belongs to requester i.
REQ-006 req_ready  out  2  one-cycle accept pulse, one-hot, to the granted requester.
REQ-007 req_data  in  2*DATA_WIDTH  transmit words; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_lock  in  2  per-requester grant lock; used only with SPI_XFER_ARB_LOCK_EN.
REQ-009 rsp_valid  out  2  one-cycle, one-hot pulse to the owner of the completed transfer.
REQ-010 rsp_data  out  DATA_WIDTH  received word; valid only while rsp_valid is non-zero.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 sck / mosi / ss_n  out  1 each  SPI master pins, mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-013 miso  in  1  SPI serial input.

Function
REQ-014 The FSM SHALL have five states: IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-015 In IDLE with any req_valid high, the FSM SHALL grant round-robin: the requester other than the last granted one wins a tie.
REQ-016 On a grant, the block SHALL pulse req_ready[winner] for that cycle, latch req_data[winner] and the owner index, and enter SETUP on the next cycle.
REQ-017 If req_valid drops before the block grants it, the block SHALL start no transfer; a requester SHALL NOT be granted while its req_valid is low.
REQ-018 SETUP SHALL last CLK_DIV cycles with ss_n=0, sck=0 and mosi=MSB of the latched word.
REQ-019 SHIFT SHALL last 2*DATA_WIDTH*CLK_DIV cycles, and sck SHALL toggle at each CLK_DIV boundary.
REQ-020 During SHIFT, miso SHALL be sampled on each sck rising edge and mosi SHALL advance one bit on each sck falling edge.
REQ-021 HOLD SHALL last CLK_DIV cycles with sck=0 and ss_n=0.
REQ-022 DONE SHALL last one cycle: rsp_valid[owner]=1 and rsp_data=the received word.
REQ-023 In DONE, ss_n SHALL return to 1 unless a lock continuation applies (REQ-029); the FSM then returns to IDLE.
REQ-024 Latency from a req_ready pulse to rsp_valid SHALL be 2*CLK_DIV + 2*DATA_WIDTH*CLK_DIV + 1 cycles.
REQ-025 After each unlocked transfer, ss_n SHALL stay high for at least one cycle before a new grant.
REQ-026 Outside SETUP/SHIFT/HOLD, sck=0 and mosi=0.

Reset
REQ-027 While reset is asserted, the outputs SHALL be: state=IDLE, ss_n=1, sck=0, mosi=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, last-granted pointer=1 (requester 0 wins the first tie).
REQ-028 If reset asserts mid-transfer, the block SHALL drive ss_n high immediately (asynchronously), SHALL NOT issue rsp_valid for the aborted transfer, and SHALL discard its partial data.

Configuration
REQ-029 With macro SPI_XFER_ARB_LOCK_EN defined: if req_lock[owner] and req_valid[owner] are both high in DONE, the block SHALL pulse req_ready[owner] in that same cycle, keep ss_n=0, latch the new word and go directly to SETUP, bypassing arbitration.
REQ-030 Without SPI_XFER_ARB_LOCK_EN: req_lock SHALL be ignored, and every transfer SHALL end with ss_n=1 and return to IDLE.

Verification
REQ-031 Single transfer: CLK_DIV=2, DATA_WIDTH=8, req 0 with data 0xA5, slave returns 0x3C -> mosi shows 10100101; rsp_valid=2'b01 with rsp_data=0x3C exactly 37 cycles after req_ready; 8 sck rising edges.
REQ-032 Contention: req_valid=2'b11 held for three transfers -> grant order 0, 1, 0; ss_n high for at least one cycle between transfers.
REQ-033 Reset mid-SHIFT: assert reset at the 5th sck rising edge -> ss_n=1 and sck=0 within that cycle; no rsp_valid; the next transfer is granted to requester 0.
REQ-034 Lock (macro defined): req 1 with lock, two back-to-back words 0x11, 0x22 -> ss_n low continuously across both; req 0 (valid throughout) is not granted until lock drops.
REQ-035 CLK_DIV=1 boundary: DATA_WIDTH=8 -> rsp_valid 19 cycles after req_ready; sck period is 2 cycles.
REQ-036 Withdrawn request: req_valid pulsed for one cycle while busy -> no grant; the FSM returns to IDLE after the current transfer, and busy=0.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
//------------------------------------------------------------------------------
// spi_xfer_arbiter
//
// Two-requester round-robin arbiter in front of a single SPI master
// (mode 0, MSB first).  A granted requester gets a one-cycle req_ready pulse.
// Its word is shifted out on mosi while miso is shifted in.  The received word
// is returned with a one-cycle rsp_valid pulse to that requester.
//
// Optional feature: define SPI_XFER_ARB_LOCK_EN to enable grant locking.
// In DONE, if req_lock[owner] and req_valid[owner] are both high, the owner
// is re-accepted in the same cycle.  ss_n stays low and arbitration is
// skipped.  Without the macro, req_lock is ignored.
//
// Parameters
//   DATA_WIDTH  bits per transfer (4..32)
//   CLK_DIV     clock cycles per SCK half-period (1..255)
//
// Ports
//   clock, reset          single clock, async active-high reset
//   req_valid[1:0]        per-requester transfer request
//   req_ready[1:0]        one-hot accept pulse to the granted requester
//   req_data              requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_lock[1:0]         per-requester grant lock (lock build only)
//   rsp_valid[1:0]        one-hot completion pulse to the transfer owner
//   rsp_data              received word, valid while rsp_valid != 0
//   busy                  high whenever the FSM is not in IDLE
//   sck, mosi, ss_n       SPI master outputs
//   miso                  SPI serial input
//------------------------------------------------------------------------------
// state | meaning
// IDLE  | ss_n high, arbitrate pending requests
// SETUP | ss_n low, sck low, MSB presented on mosi for CLK_DIV cycles
// SHIFT | 2*DATA_WIDTH sck half-periods of CLK_DIV cycles each
// HOLD  | sck low, ss_n still low, for CLK_DIV cycles
// DONE  | one cycle, response pulse to the owner
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_xfer_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  input  logic [1:0]              req_lock,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    busy,
  output logic                    sck,
  output logic                    mosi,
  output logic                    ss_n,
  input  logic                    miso
);

  if (DATA_WIDTH < 4 || DATA_WIDTH > 32) begin : g_bad_width
    $error("spi_xfer_arbiter: DATA_WIDTH out of range 4..32");
  end
  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_xfer_arbiter: CLK_DIV out of range 1..255");
  end

  localparam int HALF_W = $clog2(2*DATA_WIDTH);
  localparam logic [7:0]        DIV_LOAD  = 8'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(2*DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            div_cnt, div_nxt;
  logic [HALF_W-1:0]     half_cnt, half_nxt;
  logic [DATA_WIDTH-1:0] tx_sr, tx_nxt;
  logic [DATA_WIDTH-1:0] rx_sr, rx_nxt;
  logic                  owner, owner_nxt;
  logic                  winner;
  logic                  cont;
  logic                  in_xfer;

`ifndef SPI_XFER_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    half_nxt  = half_cnt;
    tx_nxt    = tx_sr;
    rx_nxt    = rx_sr;
    owner_nxt = owner;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_data  = '0;
    cont      = 1'b0;
    // owner doubles as the last-granted pointer: on a tie the other one wins
    winner    = (req_valid == 2'b11) ? ~owner : req_valid[1];

    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = winner ? 2'b10 : 2'b01;
          owner_nxt = winner;
          tx_nxt    = winner ? req_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_data[DATA_WIDTH-1:0];
          rx_nxt    = '0;
          div_nxt   = DIV_LOAD;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div_cnt == 8'd0) begin
          // leaving SETUP is the first sck rising edge
          rx_nxt    = {rx_sr[DATA_WIDTH-2:0], miso};
          div_nxt   = DIV_LOAD;
          half_nxt  = HALF_LOAD;
          state_nxt = SHIFT;
        end else begin
          div_nxt = div_cnt - 8'd1;
        end
      end
      SHIFT: begin
        if (div_cnt == 8'd0) begin
          div_nxt = DIV_LOAD;
          if (half_cnt == '0) begin
            state_nxt = HOLD;
          end else begin
            half_nxt = half_cnt - 1'b1;
            // odd count = sck high now, so this boundary is a falling edge
            if (half_cnt[0]) tx_nxt = {tx_sr[DATA_WIDTH-2:0], 1'b0};
            else             rx_nxt = {rx_sr[DATA_WIDTH-2:0], miso};
          end
        end else begin
          div_nxt = div_cnt - 8'd1;
        end
      end
      HOLD: begin
        if (div_cnt == 8'd0) state_nxt = DONE;
        else                 div_nxt   = div_cnt - 8'd1;
      end
      DONE: begin
        rsp_valid = owner ? 2'b10 : 2'b01;
        rsp_data  = rx_sr;
        state_nxt = IDLE;
`ifdef SPI_XFER_ARB_LOCK_EN
        if (req_lock[owner] && req_valid[owner]) begin
          cont      = 1'b1;
          req_ready = rsp_valid;
          tx_nxt    = owner ? req_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_data[DATA_WIDTH-1:0];
          rx_nxt    = '0;
          div_nxt   = DIV_LOAD;
          state_nxt = SETUP;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      owner    <= 1'b1;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      half_cnt <= half_nxt;
      tx_sr    <= tx_nxt;
      rx_sr    <= rx_nxt;
      owner    <= owner_nxt;
    end
  end

  // Pins decode straight from state so an async reset releases ss_n at once.
  assign in_xfer = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign sck     = (state == SHIFT) && half_cnt[0];
  assign mosi    = in_xfer && tx_sr[DATA_WIDTH-1];
  assign ss_n    = !(in_xfer || cont);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
`timescale 1ns/1ps

module tb_spi_xfer_arbiter;
  localparam int DW = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_lock = 2'b00;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy, sck, mosi, ss_n;
  logic        miso = 1'b0;

  logic [1:0]  fast_req_valid = 2'b00;
  logic [1:0]  fast_req_ready;
  logic [15:0] fast_req_data = 16'h0000;
  logic [1:0]  fast_req_lock = 2'b00;
  logic [1:0]  fast_rsp_valid;
  logic [7:0]  fast_rsp_data;
  logic        fast_busy, fast_sck, fast_mosi, fast_ss_n;
  logic        fast_miso = 1'b0;

  always #5 clock = ~clock;

  spi_xfer_arbiter #(.DATA_WIDTH(DW), .CLK_DIV(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_lock(req_lock), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .sck(sck), .mosi(mosi), .ss_n(ss_n), .miso(miso));

  spi_xfer_arbiter #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut_fast (
    .clock(clock), .reset(reset), .req_valid(fast_req_valid), .req_ready(fast_req_ready),
    .req_data(fast_req_data), .req_lock(fast_req_lock), .rsp_valid(fast_rsp_valid),
    .rsp_data(fast_rsp_data), .busy(fast_busy), .sck(fast_sck), .mosi(fast_mosi),
    .ss_n(fast_ss_n), .miso(fast_miso));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor + SPI slave for the main instance, sampled on the falling clock edge.
  int         cyc = 0, rdy_cyc = 0, rsp_cyc = 0, n_grants = 0, n_rsp = 0;
  int         rises = 0, sidx = 0, ss_hi_run = 0, ss_rises = 0, n_falls = 0;
  logic [1:0] grant_log [64];
  int         gap_log [64];
  logic [1:0] rsp_owner = 2'b00;
  logic [7:0] rsp_dat = 8'h00, mosi_cap = 8'h00, slave_word = 8'h00;
  logic       rsp_ssn = 1'b0, sck_prev = 1'b0, ss_prev = 1'b1;

  always @(negedge clock) begin
    cyc++;
    if (req_ready != 2'b00) begin
      rdy_cyc = cyc;
      if (n_grants < 64) grant_log[n_grants] = req_ready;
      n_grants++;
    end
    if (rsp_valid != 2'b00) begin
      rsp_cyc = cyc; rsp_owner = rsp_valid; rsp_dat = rsp_data; rsp_ssn = ss_n;
      n_rsp++;
    end
    if (sck && !sck_prev) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], mosi};
    end
    if (ss_n) begin
      sidx = 0;
      if (!ss_prev) ss_rises++;
      ss_hi_run++;
    end else begin
      if (ss_prev) begin
        if (n_falls < 64) gap_log[n_falls] = ss_hi_run;
        n_falls++;
      end
      ss_hi_run = 0;
      if (sck_prev && !sck) sidx++;
    end
    miso     = (!ss_n && sidx < DW) ? slave_word[DW-1-sidx] : 1'b0;
    sck_prev = sck;
    ss_prev  = ss_n;
  end

  int   fast_cyc = 0, fast_rdy_cyc = 0, fast_rsp_cyc = 0, fast_n_grants = 0, fast_n_rsp = 0;
  int   fast_rises = 0, fast_rise_cyc = 0, fast_per_min = 1000, fast_per_max = 0;
  logic [7:0] fast_rsp_dat = 8'h00;
  logic fast_sck_prev = 1'b0;

  always @(negedge clock) begin
    fast_cyc++;
    if (fast_req_ready != 2'b00) begin fast_rdy_cyc = fast_cyc; fast_n_grants++; end
    if (fast_rsp_valid != 2'b00) begin
      fast_rsp_cyc = fast_cyc; fast_rsp_dat = fast_rsp_data; fast_n_rsp++;
    end
    if (fast_sck && !fast_sck_prev) begin
      if (fast_rises > 0) begin
        if (fast_cyc - fast_rise_cyc < fast_per_min) fast_per_min = fast_cyc - fast_rise_cyc;
        if (fast_cyc - fast_rise_cyc > fast_per_max) fast_per_max = fast_cyc - fast_rise_cyc;
      end
      fast_rise_cyc = fast_cyc;
      fast_rises++;
    end
    fast_sck_prev = fast_sck;
  end

  task automatic wait_grants(input int target, output logic ok);
    for (int i = 0; i < 300 && n_grants < target; i++) begin @(negedge clock); #1; end
    ok = (n_grants >= target);
  endtask

  task automatic wait_rsp(input int target, output logic ok);
    for (int i = 0; i < 300 && n_rsp < target; i++) begin @(negedge clock); #1; end
    ok = (n_rsp >= target);
  endtask

  task automatic run_xfer(input logic [1:0] rv, input logic [15:0] data, input logic [7:0] sw,
                          output logic ok, output logic [1:0] grant, output logic [1:0] owner,
                          output logic [7:0] dat, output int lat, output int nrise,
                          output logic [7:0] mcap);
    int g0, r0, rb;
    logic okg, okr;
    @(posedge clock); #1;
    slave_word = sw; req_data = data; req_valid = rv;
    g0 = n_grants; r0 = n_rsp; rb = rises;
    wait_grants(g0 + 1, okg);
    grant = okg ? grant_log[g0] : 2'b00;
    @(posedge clock); #1;
    req_valid = 2'b00;
    wait_rsp(r0 + 1, okr);
    ok = okg && okr;
    owner = rsp_owner; dat = rsp_dat; lat = rsp_cyc - rdy_cyc;
    nrise = rises - rb; mcap = mosi_cap;
  endtask

  typedef struct packed {
    logic [1:0] rv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] sw;
    logic [1:0] grant;
    logic [7:0] mosi;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    logic ok, ok2;
    logic [1:0] grant, owner;
    logic [7:0] dat, mcap;
    int lat, nrise, g0, r0, f0, rb, sr0, rsp1, rdy2;
    logic ssn1;

    // rv, d0, d1, slave word, expected grant, expected mosi word
    vecs[0] = '{2'b01, 8'hA5, 8'h00, 8'h3C, 2'b01, 8'hA5};
    vecs[1] = '{2'b10, 8'h00, 8'h5A, 8'hC3, 2'b10, 8'h5A};
    vecs[2] = '{2'b11, 8'hFF, 8'h00, 8'h81, 2'b01, 8'hFF};
    vecs[3] = '{2'b11, 8'h12, 8'h80, 8'h01, 2'b10, 8'h80};
    vecs[4] = '{2'b01, 8'h00, 8'h77, 8'hFF, 2'b01, 8'h00};
    vecs[5] = '{2'b01, 8'h01, 8'h00, 8'h7E, 2'b01, 8'h01};
    vecs[6] = '{2'b11, 8'h33, 8'hCC, 8'h55, 2'b10, 8'hCC};

    // reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_ss_n", ss_n, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_xfer(vecs[v].rv, {vecs[v].d1, vecs[v].d0}, vecs[v].sw, ok, grant, owner, dat, lat, nrise, mcap);
      check($sformatf("v%0d_done", v), ok, 1'b1);
      check($sformatf("v%0d_grant", v), grant, vecs[v].grant);
      check($sformatf("v%0d_rsp_owner", v), owner, vecs[v].grant);
      check($sformatf("v%0d_rsp_data", v), dat, vecs[v].sw);
      check($sformatf("v%0d_latency", v), lat, 37);
      check($sformatf("v%0d_sck_rises", v), nrise, 8);
      check($sformatf("v%0d_mosi", v), mcap, vecs[v].mosi);
    end

`ifdef SPI_XFER_ARB_LOCK_EN
    // locked back-to-back words from requester 1; requester 0 waits
    @(posedge clock); #1;
    g0 = n_grants; r0 = n_rsp;
    req_lock = 2'b10; req_valid = 2'b10; req_data = {8'h11, 8'h00}; slave_word = 8'h00;
    wait_grants(g0 + 1, ok);
    @(posedge clock); #1;
    req_valid = 2'b11; req_data = {8'h22, 8'h00};
    sr0 = ss_rises;
    wait_rsp(r0 + 1, ok2);
    rsp1 = rsp_cyc;
    check("lock_first_done", ok && ok2, 1'b1);
    check("lock_regrant_cnt", n_grants - g0, 2);
    rdy2 = rdy_cyc;
    check("lock_regrant_same_cycle", rdy2 - rsp1, 0);
    check("lock_regrant_owner", grant_log[g0+1], 2'b10);
    @(posedge clock); #1;
    req_lock = 2'b00; req_valid = 2'b01;
    wait_rsp(r0 + 2, ok);
    check("lock_second_done", ok, 1'b1);
    check("lock_second_mosi", mosi_cap, 8'h22);
    check("lock_ss_n_rises", ss_rises - sr0, 1);
    check("lock_req0_waits", n_grants - g0, 2);
    wait_grants(g0 + 3, ok);
    check("lock_req0_granted", ok ? grant_log[g0+2] : 2'b00, 2'b01);
    @(posedge clock); #1;
    req_valid = 2'b00;
    wait_rsp(r0 + 3, ok);
`else
    // lock is ignored: requester 1 re-arbitrates through IDLE with ss_n high
    @(posedge clock); #1;
    g0 = n_grants; r0 = n_rsp;
    req_lock = 2'b10; req_valid = 2'b10; req_data = {8'h11, 8'h00}; slave_word = 8'h00;
    wait_rsp(r0 + 1, ok);
    rsp1 = rsp_cyc; ssn1 = rsp_ssn;
    wait_grants(g0 + 2, ok2);
    rdy2 = rdy_cyc;
    @(posedge clock); #1;
    req_valid = 2'b00; req_lock = 2'b00;
    check("nolock_done", ok && ok2, 1'b1);
    check("nolock_done_ss_n", ssn1, 1'b1);
    check("nolock_regrant_gap", rdy2 - rsp1, 1);
    check("nolock_regrant_owner", grant_log[g0+1], 2'b10);
    wait_rsp(r0 + 2, ok);
`endif

    // contention after reset: grant order 0, 1, 0
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    g0 = n_grants; r0 = n_rsp; f0 = n_falls;
    req_valid = 2'b11; req_data = {8'h0F, 8'hF0}; slave_word = 8'h96;
    wait_rsp(r0 + 3, ok);
    req_valid = 2'b00;
    repeat (4) @(negedge clock);
    #1;
    check("contend_done", ok, 1'b1);
    check("contend_grant_cnt", n_grants - g0, 3);
    check("contend_g0", grant_log[g0], 2'b01);
    check("contend_g1", grant_log[g0+1], 2'b10);
    check("contend_g2", grant_log[g0+2], 2'b01);
    check("contend_gap1", gap_log[f0+1] >= 1, 1'b1);
    check("contend_gap2", gap_log[f0+2] >= 1, 1'b1);

    // reset at the 5th sck rising edge of a requester-0 transfer
    @(posedge clock); #1;
    g0 = n_grants; rb = rises; slave_word = 8'hAA;
    req_valid = 2'b01; req_data = {8'h00, 8'hC3};
    wait_grants(g0 + 1, ok);
    @(posedge clock); #1;
    req_valid = 2'b00;
    for (int i = 0; i < 200 && (rises - rb) < 5; i++) begin @(negedge clock); #1; end
    check("abort_reached_5th_rise", rises - rb, 5);
    r0 = n_rsp;
    reset = 1'b1;
    #1;
    check("abort_ss_n", ss_n, 1'b1);
    check("abort_sck", sck, 1'b0);
    check("abort_busy", busy, 1'b0);
    @(posedge clock); #1; reset = 1'b0;
    repeat (45) @(negedge clock);
    #1;
    check("abort_no_rsp", n_rsp - r0, 0);
    run_xfer(2'b11, {8'h99, 8'h66}, 8'h5A, ok, grant, owner, dat, lat, nrise, mcap);
    check("post_abort_done", ok, 1'b1);
    check("post_abort_grant", grant, 2'b01);
    check("post_abort_rsp_data", dat, 8'h5A);
    check("post_abort_mosi", mcap, 8'h66);

    // requester 1 pulses for one cycle while busy: never granted
    @(posedge clock); #1;
    g0 = n_grants; r0 = n_rsp;
    req_valid = 2'b01; req_data = {8'hEE, 8'h44}; slave_word = 8'h21;
    wait_grants(g0 + 1, ok);
    @(posedge clock); #1;
    req_valid = 2'b00;
    repeat (6) @(posedge clock);
    #1;
    check("withdraw_busy", busy, 1'b1);
    req_valid = 2'b10;
    @(posedge clock); #1;
    req_valid = 2'b00;
    wait_rsp(r0 + 1, ok2);
    repeat (5) @(negedge clock);
    #1;
    check("withdraw_done", ok && ok2, 1'b1);
    check("withdraw_no_grant", n_grants - g0, 1);
    check("withdraw_idle", busy, 1'b0);
    check("withdraw_ss_n", ss_n, 1'b1);

    // CLK_DIV = 1 instance
    @(posedge clock); #1;
    fast_req_valid = 2'b01; fast_req_data = 16'h00C3; fast_miso = 1'b1;
    for (int i = 0; i < 50 && fast_n_grants == 0; i++) begin @(negedge clock); #1; end
    @(posedge clock); #1;
    fast_req_valid = 2'b00;
    for (int i = 0; i < 100 && fast_n_rsp == 0; i++) begin @(negedge clock); #1; end
    check("fast_done", fast_n_rsp, 1);
    check("fast_latency", fast_rsp_cyc - fast_rdy_cyc, 19);
    check("fast_rsp_data", fast_rsp_dat, 8'hFF);
    check("fast_sck_rises", fast_rises, 8);
    check("fast_sck_period_min", fast_per_min, 2);
    check("fast_sck_period_max", fast_per_max, 2);
    repeat (2) @(negedge clock);
    #1;
    check("fast_idle_busy", fast_busy, 1'b0);
    check("fast_idle_ss_n", fast_ss_n, 1'b1);
    check("fast_idle_mosi", fast_mosi, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
